// File: rtl/video_to_fifo_packer.sv
// Packs a registered 24-bit RGB stream four pixels per 128-bit FIFO word and queues one
// AXI full-burst write request per completed line; sticky flags report drops and length errors.
module video_to_fifo_packer_lane #(
  parameter int PIX_W = 24
) (
  input  logic             video_clk,
  input  logic             video_rst_n,
  input  logic             ld,
  input  logic             clr,
  input  logic [PIX_W-1:0] pix,
  output logic [PIX_W-1:0] q_nxt,
  output logic [PIX_W-1:0] q
);
  always_comb q_nxt = ld ? pix : (clr ? '0 : q);

  always_ff @(posedge video_clk or negedge video_rst_n)
    if (!video_rst_n) q <= '0;
    else              q <= q_nxt;
endmodule

module video_to_fifo_packer #(
  parameter int H_ACTIVE = 1920,
  parameter int PEND_W   = 3
) (
  input  logic         video_clk,
  input  logic         video_rst_n,
  input  logic         video_vs_in,
  input  logic         video_hs_in,
  input  logic         video_de_in,
  input  logic [23:0]  video_data_in,
  input  logic         fifo_full,
  output logic         fifo_wr_en,
  output logic [127:0] fifo_wr_data,
  output logic         AXI_FULL_BURST_VALID,
  input  logic         AXI_FULL_BURST_READY,
  output logic         frame_start,
  input  logic         err_clr,
  output logic         fifo_ovf,
  output logic         req_ovf,
  output logic         line_len_err,
  output logic [15:0]  last_line_words
);
  localparam int NUM_LANES = 4;
  localparam int PIX_W     = 24;
  localparam int WORD_W    = 128 / NUM_LANES;
  localparam logic [15:0]       EXP_WORDS = 16'((H_ACTIVE + 3) / 4);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  logic             vs_d1, vs_d2, de_d1, de_d2, hs_d1_unused;
  logic [PIX_W-1:0] data_d1;
  logic [1:0]       lane_cnt, lane_sel;
  logic [15:0]      word_cnt, line_words;
  logic [PEND_W-1:0] pend_cnt, pend_nxt;
  logic             wr_vld;
  logic             vs_rise, de_fall, start_word, full_issue, flush, issue, line_end;
  logic             hs_acc, req_lost;
  logic [NUM_LANES-1:0][PIX_W-1:0] lane_q, lane_nxt;
  logic [127:0]     word_nxt;

  always_ff @(posedge video_clk or negedge video_rst_n)
    if (!video_rst_n) begin
      {vs_d1, vs_d2, de_d1, de_d2, hs_d1_unused} <= '0;
      data_d1 <= '0;
    end else begin
      vs_d1 <= video_vs_in;  vs_d2 <= vs_d1;
      de_d1 <= video_de_in;  de_d2 <= de_d1;
      hs_d1_unused <= video_hs_in;
      data_d1 <= video_data_in;
    end

  // A frame start overrides any line end seen on the same cycle: the partial word is discarded.
  assign vs_rise    = vs_d1 & ~vs_d2;
  assign de_fall    = ~de_d1 & de_d2;
  assign lane_sel   = vs_rise ? 2'd0 : lane_cnt;
  assign start_word = de_d1 & (lane_sel == 2'd0);
  assign full_issue = de_d1 & (lane_sel == 2'd3);
  assign line_end   = de_fall & ~vs_rise;
  assign flush      = line_end & (lane_cnt != 2'd0);
  assign issue      = full_issue | flush;
  assign line_words = word_cnt + {15'd0, flush};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      video_to_fifo_packer_lane #(.PIX_W(PIX_W)) u_lane (
        .video_clk   (video_clk),
        .video_rst_n (video_rst_n),
        .ld          (de_d1 && (lane_sel == 2'(g))),
        .clr         (start_word),
        .pix         (data_d1),
        .q_nxt       (lane_nxt[g]),
        .q           (lane_q[g])
      );
      // lane 0 is the first pixel and sits in the top 32-bit slot
      assign word_nxt[(NUM_LANES-1-g)*WORD_W +: WORD_W] = {8'd0, lane_nxt[g]};
    end
  endgenerate

  assign hs_acc   = AXI_FULL_BURST_VALID & AXI_FULL_BURST_READY;
  assign req_lost = line_end & ~hs_acc & (pend_cnt == PEND_MAX);

  always_comb begin
    pend_nxt = pend_cnt;
    if (line_end && !hs_acc && !req_lost) pend_nxt = pend_cnt + PEND_W'(1);
    else if (!line_end && hs_acc)         pend_nxt = pend_cnt - PEND_W'(1);
  end

  // Full is judged in the cycle the strobe would be driven, so the FIFO never sees a write while full.
  assign fifo_wr_en = wr_vld & ~fifo_full;

  always_ff @(posedge video_clk or negedge video_rst_n)
    if (!video_rst_n) begin
      lane_cnt             <= '0;
      word_cnt             <= '0;
      pend_cnt             <= '0;
      wr_vld               <= 1'b0;
      fifo_wr_data         <= '0;
      AXI_FULL_BURST_VALID <= 1'b0;
      frame_start          <= 1'b0;
      fifo_ovf             <= 1'b0;
      req_ovf              <= 1'b0;
      line_len_err         <= 1'b0;
      last_line_words      <= '0;
    end else begin
      if (vs_rise)       lane_cnt <= de_d1 ? 2'd1 : 2'd0;
      else if (de_d1)    lane_cnt <= lane_cnt + 2'd1;
      else if (de_fall)  lane_cnt <= 2'd0;

      if (vs_rise || line_end) word_cnt <= '0;
      else if (issue)          word_cnt <= word_cnt + 16'd1;

      wr_vld <= issue;
      if (issue) fifo_wr_data <= word_nxt;
      if (line_end) last_line_words <= line_words;

      pend_cnt             <= pend_nxt;
      AXI_FULL_BURST_VALID <= (pend_nxt != '0);
      frame_start          <= vs_rise;

      fifo_ovf     <= (wr_vld & fifo_full) | (fifo_ovf & ~err_clr);
      req_ovf      <= req_lost | (req_ovf & ~err_clr);
      line_len_err <= (line_end & (line_words != EXP_WORDS)) | (line_len_err & ~err_clr);
    end
endmodule
